// File: rtl/mcp23s17_spi_sequencer_if.sv
// Host request/response handshake plus the SPI pins of mcp23s17_spi_sequencer.
// master = host/board side, slave = the sequencer itself.
interface mcp23s17_spi_sequencer_if;
  logic       start_i;
  logic       rw_i;
  logic [7:0] reg_i;
  logic [7:0] wdata_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] rdata_o;
  logic       spiClk_o;
  logic       cs_o;
  logic       mosi_o;
  logic       miso_i;

  modport master (
    output start_i, rw_i, reg_i, wdata_i, miso_i,
    input  busy_o, done_o, rdata_o, spiClk_o, cs_o, mosi_o
  );

  modport slave (
    input  start_i, rw_i, reg_i, wdata_i, miso_i,
    output busy_o, done_o, rdata_o, spiClk_o, cs_o, mosi_o
  );
endinterface

// File: rtl/mcp23s17_spi_sequencer.sv
// SPI mode-0 master running one opcode/register/data transaction to an MCP23S17 per start pulse.
// Define MCP_CAPTURE_ALL_EN to expose the full 24-bit received frame on capture_o.
module mcp23s17_spi_sequencer #(
  parameter int       CLK_DIV = 4,
  parameter bit [2:0] HW_ADDR = 3'b000
) (
  input  logic        sysClk,
  input  logic        reset,
`ifdef MCP_CAPTURE_ALL_EN
  output logic [23:0] capture_o,
`endif
  mcp23s17_spi_sequencer_if.slave bus
);
  // state    | meaning
  // IDLE     | cs high, waiting for start_i
  // CS_SETUP | cs low, CLK_DIV cycles before the first spiClk rise
  // SHIFT    | 24 bits, each CLK_DIV cycles low then CLK_DIV cycles high
  // CS_HOLD  | cs still low for CLK_DIV cycles after the last fall
  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef MCP_CAPTURE_ALL_EN
  localparam int RX_W = 24;
`else
  localparam int RX_W = 8;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [23:0]      tx_q, tx_d;
  logic [RX_W-1:0]  rx_q, rx_d;
  logic             rd_q, rd_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             div_tc;
  logic             finish;

  assign div_tc = (div_q == '0);
  assign finish = (state_q == CS_HOLD) && div_tc;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = CS_SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          rd_d    = bus.rw_i;
          div_d   = DIV_LAST;
          bit_d   = 5'd0;
          tx_d    = {4'b0100, HW_ADDR, bus.rw_i, bus.reg_i,
                     bus.rw_i ? 8'h00 : bus.wdata_i};
        end
      end
      CS_SETUP: begin
        div_d = div_q - 1'b1;
        if (div_tc) begin
          state_d = SHIFT;
          div_d   = DIV_LAST;
        end
      end
      SHIFT: begin
        div_d = div_q - 1'b1;
        // miso is captured in the first cycle spiClk is high
        if (sclk_q && (div_q == DIV_LAST)) rx_d = {rx_q[RX_W-2:0], bus.miso_i};
        if (div_tc) begin
          div_d  = DIV_LAST;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // 24th shift empties tx, leaving mosi low through CS_HOLD
            tx_d = {tx_q[22:0], 1'b0};
            if (bit_q == 5'd23) state_d = CS_HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end
      end
      CS_HOLD: begin
        div_d = div_q - 1'b1;
        if (div_tc) begin
          state_d = IDLE;
          div_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rd_q) rdata_d = rx_q[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MCP_CAPTURE_ALL_EN
  logic [23:0] capture_q;

  always_ff @(posedge sysClk) begin
    if (reset)       capture_q <= 24'h0;
    else if (finish) capture_q <= rx_q;
  end

  assign capture_o = capture_q;
`endif

  assign bus.spiClk_o = sclk_q;
  assign bus.cs_o     = cs_q;
  assign bus.mosi_o   = tx_q[23];
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_mcp23s17_spi_sequencer.sv
// Directed bench for mcp23s17_spi_sequencer: two instances (HW_ADDR 0 and 2) share stimulus,
// an inline monitor decodes mosi, drives miso on falling edges and times cs/done.
module tb_mcp23s17_spi_sequencer;
  logic       sysClk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [7:0] reg_a;
  logic [7:0] wdata;
  logic       miso;
  logic       sel;

  always #5 sysClk = ~sysClk;

  mcp23s17_spi_sequencer_if if0();
  mcp23s17_spi_sequencer_if if2();

  assign if0.start_i = start;
  assign if0.rw_i    = rw;
  assign if0.reg_i   = reg_a;
  assign if0.wdata_i = wdata;
  assign if0.miso_i  = miso;
  assign if2.start_i = start;
  assign if2.rw_i    = rw;
  assign if2.reg_i   = reg_a;
  assign if2.wdata_i = wdata;
  assign if2.miso_i  = miso;

`ifdef MCP_CAPTURE_ALL_EN
  logic [23:0] cap0, cap2;
`endif

  mcp23s17_spi_sequencer #(.CLK_DIV(4), .HW_ADDR(3'b000)) u_dut0 (
    .sysClk(sysClk),
    .reset(reset),
`ifdef MCP_CAPTURE_ALL_EN
    .capture_o(cap0),
`endif
    .bus(if0.slave)
  );

  mcp23s17_spi_sequencer #(.CLK_DIV(4), .HW_ADDR(3'b010)) u_dut2 (
    .sysClk(sysClk),
    .reset(reset),
`ifdef MCP_CAPTURE_ALL_EN
    .capture_o(cap2),
`endif
    .bus(if2.slave)
  );

  wire       cs    = sel ? if2.cs_o     : if0.cs_o;
  wire       sclk  = sel ? if2.spiClk_o : if0.spiClk_o;
  wire       mosi  = sel ? if2.mosi_o   : if0.mosi_o;
  wire       busy  = sel ? if2.busy_o   : if0.busy_o;
  wire       done  = sel ? if2.done_o   : if0.done_o;
  wire [7:0] rdata = sel ? if2.rdata_o  : if0.rdata_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          done_cyc = -1;
  int          cs_fall_cyc = -1;
  int          first_rise_cyc = -1;
  int          nbits = 0;
  int          miso_idx = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [23:0] mosi_sr = '0;
  logic [23:0] miso_pat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one cycle: advance to the falling edge and run the pin-level monitor / miso model
  task automatic tick();
    @(negedge sysClk);
    cyc++;
    if (prev_cs && !cs) begin
      cs_fall_cyc    = cyc;
      first_rise_cyc = -1;
      nbits          = 0;
      mosi_sr        = '0;
      miso_idx       = 23;
      miso           = miso_pat[23];
    end
    if (!prev_sclk && sclk) begin
      mosi_sr = {mosi_sr[22:0], mosi};
      if (nbits == 0) first_rise_cyc = cyc;
      nbits++;
    end
    if (prev_sclk && !sclk && !cs && miso_idx > 0) begin
      miso_idx--;
      miso = miso_pat[miso_idx];
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_sclk = sclk;
    prev_cs   = cs;
  endtask

  task automatic run_txn(input logic s, input logic r, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [23:0] pat, output int t0);
    int dc;
    bit ok;
    sel      = s;
    rw       = r;
    reg_a    = ra;
    wdata    = wd;
    miso_pat = pat;
    dc       = done_count;
    t0       = cyc;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (done_count != dc) ok = 1'b1;
    end
    chk("txn_completed", {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [7:0]  ra;
    logic [7:0]  wd;
    logic [23:0] pat;
    logic [23:0] exp_mosi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0;
    int dc;
    bit got;

    vecs[0] = '{1'b0, 1'b0, 8'h12, 8'hA5, 24'h000000, 24'h4012A5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h13, 8'h00, 24'h7999E4, 24'h451300, 8'hE4};
    vecs[2] = '{1'b1, 1'b0, 8'h0A, 8'h3C, 24'hFFFFFF, 24'h440A3C, 8'hE4};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 24'h00005A, 24'h41FF00, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h77, 24'h123456, 24'h450000, 8'h56};

    sel   = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    rw    = 1'b1;
    reg_a = 8'h13;
    wdata = 8'h00;
    miso  = 1'b0;

    // reset idle, with start held high during reset
    repeat (3) tick();
    chk("rst_cs", {31'b0, cs}, 32'd1);
    chk("rst_sclk", {31'b0, sclk}, 32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", {24'b0, rdata}, 32'h00);
    chk("rst_cs_dut2", {31'b0, if2.cs_o}, 32'd1);
    chk("rst_no_cs_fall", cs_fall_cyc, 32'hFFFFFFFF);
`ifdef MCP_CAPTURE_ALL_EN
    chk("rst_capture", {8'b0, cap0}, 32'h0);
`endif
    start = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_no_done", done_count, 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].s, vecs[v].r, vecs[v].ra, vecs[v].wd, vecs[v].pat, t0);
      chk($sformatf("v%0d_cs_fall", v), cs_fall_cyc - t0, 32'd1);
      chk($sformatf("v%0d_first_rise", v), first_rise_cyc - t0, 32'd9);
      chk($sformatf("v%0d_done_lat", v), done_cyc - t0, 32'd201);
      chk($sformatf("v%0d_nbits", v), nbits, 32'd24);
      chk($sformatf("v%0d_byte0", v), {24'b0, mosi_sr[23:16]}, {24'b0, vecs[v].exp_mosi[23:16]});
      chk($sformatf("v%0d_byte1", v), {24'b0, mosi_sr[15:8]}, {24'b0, vecs[v].exp_mosi[15:8]});
      chk($sformatf("v%0d_byte2", v), {24'b0, mosi_sr[7:0]}, {24'b0, vecs[v].exp_mosi[7:0]});
      chk($sformatf("v%0d_rdata", v), {24'b0, rdata}, {24'b0, vecs[v].exp_rdata});
      chk($sformatf("v%0d_cs_at_done", v), {31'b0, cs}, 32'd1);
      chk($sformatf("v%0d_busy_at_done", v), {31'b0, busy}, 32'd0);
`ifdef MCP_CAPTURE_ALL_EN
      chk($sformatf("v%0d_capture", v), {8'b0, (vecs[v].s ? cap2 : cap0)}, {8'b0, vecs[v].pat});
`endif
      tick();
      chk($sformatf("v%0d_done_one_cycle", v), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_mosi_idle", v), {31'b0, mosi}, 32'd0);
    end

    // back-to-back with start held, then a mid-transaction start pulse
    sel      = 1'b0;
    rw       = 1'b0;
    reg_a    = 8'h12;
    wdata    = 8'hA5;
    miso_pat = '0;
    dc       = done_count;
    start    = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      if (done_count == dc + 1 && cs_fall_cyc > done_cyc) got = 1'b1;
    end
    start = 1'b0;
    chk("b2b_second_accept", {31'b0, got}, 32'd1);
    chk("b2b_cs_gap", cs_fall_cyc - done_cyc, 32'd1);
    repeat (60) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (done_count == dc + 2) got = 1'b1;
    end
    chk("b2b_second_done", {31'b0, got}, 32'd1);
    chk("b2b_second_frame", {8'b0, mosi_sr}, 32'h004012A5);
    repeat (250) tick();
    chk("b2b_txn_count", done_count - dc, 32'd2);
    chk("b2b_cs_idle", {31'b0, cs}, 32'd1);

    // reset during bit 10 of a read
    sel      = 1'b1;
    rw       = 1'b1;
    reg_a    = 8'h13;
    miso_pat = 24'h7999E4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (nbits == 11) got = 1'b1;
    end
    chk("mid_reached_bit10", {31'b0, got}, 32'd1);
    chk("mid_rdata_before", {24'b0, rdata}, 32'h56);
    reset = 1'b1;
    dc    = done_count;
    tick();
    chk("mid_cs", {31'b0, cs}, 32'd1);
    chk("mid_sclk", {31'b0, sclk}, 32'd0);
    chk("mid_mosi", {31'b0, mosi}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_rdata", {24'b0, rdata}, 32'h00);
    tick();
    reset = 1'b0;
    repeat (250) tick();
    chk("mid_no_done", done_count - dc, 32'd0);
    run_txn(1'b1, 1'b0, 8'h0A, 8'h3C, 24'h0, t0);
    chk("post_rst_done_lat", done_cyc - t0, 32'd201);
    chk("post_rst_frame", {8'b0, mosi_sr}, 32'h00440A3C);
    chk("post_rst_rdata", {24'b0, rdata}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcp23s17_spi_sequencer.md
Name: mcp23s17_spi_sequencer

Overview:
- SPI master sequencer that runs complete MCP23S17-style register transactions: opcode byte, register address byte, then one data byte.
- Drives the external-facing SPI pins `spiClk`, `cs` and `mosi`, and samples `miso`. These are the pins the SPISlave expander model receives.
- SPI mode 0:
  - master changes `mosi` on SPI falling edges;
  - slave samples `mosi` on rising edges;
  - master samples `miso` on rising edges.
- Sits between a CPU-side register/IO block and the expander; one transaction per `start_i` pulse.

Parameters:
- CLK_DIV, 4: `sysClk` cycles per SPI half-period. Legal range ≥ 2; 4 is the minimum that guarantees the slave's 3-flop CDC sees every edge.
- HW_ADDR, 3'b000: expander hardware address placed in opcode bits [3:1].

Ports:
- sysClk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  transaction request; sampled only in IDLE.
- rw_i  in  1  1 = read, 0 = write; latched with `start_i`.
- reg_i  in  8  register address; latched with `start_i`.
- wdata_i  in  8  write data; latched with `start_i`, ignored on reads.
- busy_o  out  1  high from the cycle after `start_i` is accepted until `done_o`.
- done_o  out  1  one-cycle pulse at transaction end.
- rdata_o  out  8  third received byte of the last read; holds until the next read completes.
- spiClk_o  out  1  SPI clock; idles low.
- cs_o  out  1  active-low chip select; idles high.
- mosi_o  out  1  master out.
- miso_i  in  1  master in; treated as already synchronous to `sysClk`.

Behaviour:
- Reset values: `cs_o` = 1, `spiClk_o` = 0, `mosi_o` = 0, `busy_o` = 0, `done_o` = 0, `rdata_o` = 8'h00; state = IDLE; all counters 0.
- Reset asserted mid-transaction aborts immediately to the reset values. No `done_o` is produced.
- Latched at acceptance: `tx_shift[23:0]` = {opcode, reg_i, third}.
  - opcode = {4'b0100, HW_ADDR, rw_i}
  - third = 8'h00 if read, else wdata_i
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → IDLE.
- IDLE:
  - `start_i` = 1 at cycle 0 → at cycle 1: state = CS_SETUP, `cs_o` = 0, `busy_o` = 1, `mosi_o` = tx_shift[23].
  - `start_i` while not IDLE is ignored; there is no queueing.
- CS_SETUP:
  - Holds for CLK_DIV cycles with `spiClk_o` = 0.
  - Then enters SHIFT at cycle 1+CLK_DIV.
- SHIFT:
  - Runs 24 bits; each bit is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - Rising edge k (k = 0..23) occurs at cycle 1+2·CLK_DIV+2k·CLK_DIV. That cycle shifts `miso_i` into `rx_shift[23:0]` LSB-first-in (MSB of each byte received first).
  - On each falling edge after bits 0..22, the next tx bit is driven on `mosi_o` in the same cycle `spiClk_o` returns low.
  - After the falling edge of bit 23, `mosi_o` = 0 and state = CS_HOLD.
  - Counters:
    - half-period counter, modulo CLK_DIV;
    - bit counter 5 bits, 0..23, with no wrap-around beyond 23;
    - byte index = bit counter[4:3].
- CS_HOLD:
  - Holds for CLK_DIV cycles with `spiClk_o` = 0 and `cs_o` = 0.
  - Then `cs_o` = 1, `busy_o` = 0, `done_o` = 1 for one cycle, state = IDLE.
  - On reads, `rdata_o` is updated with rx_shift[7:0] in the same cycle.
- Total latency: `done_o` at cycle 1+50·CLK_DIV after `start_i` (201 for CLK_DIV = 4).
- `start_i` held high continuously: a new transaction is accepted in the cycle after `done_o`. This gives a minimum `cs_o`-high gap of 1 cycle, and CS_SETUP still guarantees CLK_DIV cycles before the first rising edge.
- `rdata_o` is never modified by write transactions.

Optional Feature:
- Macro MCP_CAPTURE_ALL_EN.
- Defined:
  - Adds output port `capture_o[23:0]` = full `rx_shift` from the last transaction (read or write).
  - Updated on the `done_o` cycle; reset value 24'h0.
- Undefined: the port and its register are absent. `rx_shift` keeps only what is needed for `rdata_o`.

Test Plan:
- Reset idle: hold reset 3 cycles → `cs_o` = 1, `spiClk_o` = 0, `mosi_o` = 0, `busy_o` = 0, `rdata_o` = 00; `start_i` with reset = 1 produces no activity.
- Write: CLK_DIV = 4, HW_ADDR = 0, rw = 0, reg = 12, wdata = A5 → bench decodes 24 `mosi` bits at rising edges as 40, 12, A5.
  - `cs_o` falls at cycle 1; first rise at cycle 9; `done_o` at cycle 201.
  - `rdata_o` unchanged.
- Read: HW_ADDR = 3'b010, rw = 1, reg = 13; bench MISO model returns 79, 99, E4 changing on falling edges → `mosi` bytes 45, 13, 00 and `rdata_o` = E4 on `done_o`.
  - With MCP_CAPTURE_ALL_EN: `capture_o` = 7999E4.
- Back-to-back: `start_i` held high for two transactions → second `cs_o` fall exactly 1 cycle after first `done_o`. A `start_i` pulse mid-transaction is ignored, so the transaction count is 2.
- Reset mid-operation: assert reset at bit 10 of a read → next cycle `cs_o` = 1, `spiClk_o` = 0, no `done_o`, `rdata_o` = 00. A following write completes normally.
- Integration with SPISlave model at CLK_DIV = 4 → slave `rx_byte` equals each transmitted byte at byte end.
